// File: rtl/axis_sa_arbiter.sv
// Tag FIFO: requester IDs of packets issued to the array, oldest at rd_dat.
// Latency: a pushed entry reaches rd_dat on the cycle after the push.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module axis_sa_tag_fifo #(
    parameter int W = 1,
    parameter int D = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [W-1:0]         wr_dat,
    input  logic                 pop,
    output logic [W-1:0]         rd_dat,
    output logic [$clog2(D):0]   count
);
    localparam int AW = $clog2(D);

    logic [W-1:0]  mem [D];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Pointers wrap naturally because D is a power of two; simultaneous push/pop keeps count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: entries are only read once count says they are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_dat;
    end

    assign rd_dat = mem[rd_ptr];
endmodule

// Shares one axis_sa array among N stream requesters with packet round-robin and in-order result return.
// Latency: 0 cycles per beat on both paths, plus a 1-cycle arbitration bubble per input packet.
// Backpressure: sa_s_ready passes to the granted requester only; m_ready of the FIFO-head requester drives sa_m_ready.
module axis_sa_arbiter #(
    parameter int N   = 2,
    parameter int WXK = 24,
    parameter int WYB = 22,
    parameter int D   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     s_valid,
    output logic [N-1:0]     s_ready,
    input  logic [N-1:0]     s_last,
    input  logic [N*WXK-1:0] s_data,
    output logic             sa_s_valid,
    input  logic             sa_s_ready,
    output logic             sa_s_last,
    output logic [WXK-1:0]   sa_s_data,
    input  logic             sa_m_valid,
    output logic             sa_m_ready,
    input  logic             sa_m_last,
    input  logic [WYB-1:0]   sa_m_data,
    output logic [N-1:0]     m_valid,
    input  logic [N-1:0]     m_ready,
    output logic             m_last,
    output logic [WYB-1:0]   m_data,
    output logic             err
);
    localparam int WT = $clog2(N);
    localparam int WC = $clog2(D) + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]    state;
    logic [WT-1:0] grant;
    logic [WT-1:0] last_grant;
    logic [WT-1:0] next_id;
    logic          req_found;
    logic [WT-1:0] head;
    logic [WC-1:0] count;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          busy_last;

    // Round-robin pick: first requester with s_valid strictly after last_grant, wrapping.
    always_comb begin
        next_id   = last_grant;
        req_found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            if (!req_found && s_valid[(int'(last_grant) + i) % N]) begin
                req_found = 1'b1;
                next_id   = WT'((int'(last_grant) + i) % N);
            end
        end
    end

    // Full uses the registered count, so a same-cycle result pop cannot open a slot.
    assign fifo_full = (count == WC'(D));
    assign push      = (state == IDLE) && req_found && !fifo_full;
    assign busy_last = (state == BUSY) && s_valid[grant] && sa_s_ready && s_last[grant];
    assign pop       = sa_m_valid && sa_m_ready && sa_m_last;

    // Grant is latched in IDLE and held until the granted packet's last beat is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= WT'(N - 1);
        end else if (state == IDLE) begin
            if (push) begin
                state      <= BUSY;
                grant      <= next_id;
                last_grant <= next_id;
            end
        end else if (busy_last) begin
            state <= IDLE;
        end
    end

    axis_sa_tag_fifo #(
        .W (WT),
        .D (D)
    ) u_tag_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .wr_dat (next_id),
        .pop    (pop),
        .rd_dat (head),
        .count  (count)
    );

    // Forward path: only the granted requester is connected, and only while BUSY.
    always_comb begin
        s_ready    = '0;
        sa_s_valid = 1'b0;
        sa_s_last  = 1'b0;
        sa_s_data  = '0;
        if (state == BUSY) begin
            sa_s_valid     = s_valid[grant];
            sa_s_last      = s_last[grant];
            sa_s_data      = s_data[int'(grant)*WXK +: WXK];
            s_ready[grant] = sa_s_ready;
        end
    end

    // Return path: results belong to the oldest outstanding tag; nothing is accepted with no tag.
    always_comb begin
        m_valid    = '0;
        sa_m_ready = 1'b0;
        if (count != '0) begin
            m_valid[head] = sa_m_valid;
            sa_m_ready    = m_ready[head];
        end
    end

    assign m_data = sa_m_data;
    assign m_last = sa_m_last;

    // Sticky error: the array produced a beat no request is waiting for.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            err <= 1'b0;
        else if (sa_m_valid && count == '0) err <= 1'b1;
    end
endmodule

// File: tb/tb_axis_sa_arbiter.sv
// Bench for axis_sa_arbiter: random requesters and a stand-in array against a packet-level model.
// Latency: beats are checked in the cycle they are accepted.
// Backpressure: sa_s_ready, sa_m_valid and m_ready are randomised per test.
module tb_axis_sa_arbiter;
    localparam int N   = 2;
    localparam int WXK = 16;
    localparam int WYB = 22;
    localparam int D   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     s_valid;
    logic [N-1:0]     s_ready;
    logic [N-1:0]     s_last;
    logic [N*WXK-1:0] s_data;
    logic             sa_s_valid;
    logic             sa_s_ready;
    logic             sa_s_last;
    logic [WXK-1:0]   sa_s_data;
    logic             sa_m_valid;
    logic             sa_m_ready;
    logic             sa_m_last;
    logic [WYB-1:0]   sa_m_data;
    logic [N-1:0]     m_valid;
    logic [N-1:0]     m_ready;
    logic             m_last;
    logic [WYB-1:0]   m_data;
    logic             err;

    axis_sa_arbiter #(.N(N), .WXK(WXK), .WYB(WYB), .D(D)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last), .s_data(s_data),
        .sa_s_valid(sa_s_valid), .sa_s_ready(sa_s_ready), .sa_s_last(sa_s_last), .sa_s_data(sa_s_data),
        .sa_m_valid(sa_m_valid), .sa_m_ready(sa_m_ready), .sa_m_last(sa_m_last), .sa_m_data(sa_m_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .m_data(m_data),
        .err(err)
    );

    always #5 clk = ~clk;

    // Requester sources, model expectations and array stand-in state.
    logic [16:0] rq      [N][$];   // beats still to be offered, {last, data}
    logic [16:0] exp_q   [N][$];   // beats the model expects to see forwarded
    logic [22:0] exp_res [N][$];   // result beats the model expects per requester
    int          dest_q[$];        // issue order of completed input packets
    logic [22:0] res_q[$];         // array stand-in output beats
    logic [15:0] cur_pkt[$];
    int          grant_log[$];
    int          res_log[$];
    int          model_last, cur_g, cyc, pop_cyc, pkts_issued, pkts_delivered, fwd_beats;
    int          sa_rdy_pct, mvld_pct, mrdy_mode, mrdy_target;
    bit          in_pkt, mvld_hold, force_mvld, watch_rdy;
    logic [N-1:0] last_s_ready;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    function automatic int first_set(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Y[r][c] = sum over beats of x[r]*k[c]; result beat c carries {Y[1][c], Y[0][c]}.
    function automatic logic [43:0] golden(input logic [15:0] pkt[$]);
        int y [2][2];
        for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++) y[r][c] = 0;
        foreach (pkt[b])
            for (int r = 0; r < 2; r++)
                for (int c = 0; c < 2; c++)
                    y[r][c] += int'(pkt[b][4*r +: 4]) * int'(pkt[b][8+4*c +: 4]);
        return {11'(y[1][1]), 11'(y[0][1]), 11'(y[1][0]), 11'(y[0][0])};
    endfunction

    // Next grantee by round robin among requesters that still have packets queued.
    function automatic int predict();
        for (int i = 1; i <= N; i++) begin
            int idx = (model_last + i) % N;
            if (exp_q[idx].size() > 0) return idx;
        end
        return -1;
    endfunction

    function automatic int outstanding();
        int n = dest_q.size();
        for (int i = 0; i < N; i++) n += exp_q[i].size() + rq[i].size();
        return n;
    endfunction

    task automatic load_pkt(input int id, input int len);
        logic [15:0] pkt[$];
        logic [15:0] b;
        logic [43:0] g;
        for (int i = 0; i < len; i++) begin
            b = 16'($urandom);
            pkt.push_back(b);
            rq[id].push_back({i == len - 1, b});
            exp_q[id].push_back({i == len - 1, b});
        end
        g = golden(pkt);
        exp_res[id].push_back({1'b0, g[21:0]});
        exp_res[id].push_back({1'b1, g[43:22]});
    endtask

    // One clock: drive at negedge, settle, check and update model, then cross the posedge.
    task automatic step();
        int g, d;
        logic [16:0] hb;
        logic [22:0] rb;
        logic [43:0] gv;
        logic [N-1:0] eoh;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0) begin
                hb = rq[i][0];
                s_valid[i] = 1'b1;
                s_last[i]  = hb[16];
                s_data[i*WXK +: WXK] = hb[15:0];
            end else begin
                s_valid[i] = 1'b0;
                s_last[i]  = 1'b0;
                s_data[i*WXK +: WXK] = '0;
            end
        end
        sa_s_ready = ($urandom_range(99) < sa_rdy_pct);
        if (force_mvld) begin
            sa_m_valid = 1'b1; sa_m_last = 1'b0; sa_m_data = '0;
        end else if (res_q.size() > 0 && (mvld_hold || $urandom_range(99) < mvld_pct)) begin
            rb = res_q[0];
            sa_m_valid = 1'b1; sa_m_last = rb[22]; sa_m_data = rb[21:0];
        end else begin
            sa_m_valid = 1'b0; sa_m_last = 1'b0; sa_m_data = '0;
        end
        case (mrdy_mode)
            0:       m_ready = '0;
            1:       m_ready = '1;
            3:       m_ready = (pkts_delivered < mrdy_target) ? '1 : '0;
            default: m_ready = N'($urandom);
        endcase
        #1;
        last_s_ready = s_ready;
        g   = in_pkt ? cur_g : predict();
        eoh = onehot(g);
        if (s_ready != '0) check("rdy_granted_only", s_ready & ~eoh, '0);
        if (watch_rdy && s_ready != '0) begin
            check("regrant_delay", cyc - pop_cyc, 2);
            watch_rdy = 1'b0;
        end
        if (sa_s_valid && sa_s_ready) begin
            if (g < 0) begin
                check("spurious_beat", sa_s_valid, 1'b0);
            end else begin
                hb = exp_q[g].pop_front();
                check("fwd_beat", {sa_s_last, sa_s_data}, hb);
                check("fwd_src_rdy", s_ready, eoh);
                fwd_beats++;
                if (!in_pkt) begin
                    in_pkt = 1'b1; cur_g = g; model_last = g;
                    cur_pkt.delete();
                    grant_log.push_back(first_set(s_ready));
                end
                cur_pkt.push_back(sa_s_data);
                if (hb[16]) begin
                    gv = golden(cur_pkt);
                    res_q.push_back({1'b0, gv[21:0]});
                    res_q.push_back({1'b1, gv[43:22]});
                    dest_q.push_back(g);
                    pkts_issued++;
                    in_pkt = 1'b0;
                end
            end
        end
        for (int i = 0; i < N; i++)
            if (s_valid[i] && s_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (dest_q.size() == 0) begin
            check("m_valid_no_tag", m_valid, '0);
            if (force_mvld) check("sa_m_ready_no_tag", sa_m_ready, 1'b0);
        end else begin
            d = dest_q[0];
            check("m_valid_route", m_valid, sa_m_valid ? onehot(d) : '0);
            check("sa_m_ready_route", sa_m_ready, m_ready[d]);
            if (sa_m_valid && sa_m_ready) begin
                if (exp_res[d].size() == 0) begin
                    check("extra_result", sa_m_valid, 1'b0);
                end else begin
                    rb = exp_res[d].pop_front();
                    check("result_beat", {m_last, m_data}, rb);
                    if (rb[22]) begin
                        res_log.push_back(first_set(m_valid));
                        void'(dest_q.pop_front());
                        pkts_delivered++;
                        pop_cyc = cyc;
                    end
                end
                if (res_q.size() > 0) void'(res_q.pop_front());
                mvld_hold = 1'b0;
            end else begin
                mvld_hold = sa_m_valid;
            end
        end
        @(posedge clk);
    endtask

    task automatic drain(input string tag, input int limit);
        int n = 0;
        while (outstanding() != 0 && n < limit) begin
            step();
            n++;
        end
        check({tag, "_drain"}, outstanding(), 0);
    endtask

    // Reset with all inputs active, check outputs are forced low, then confirm the FIFO is empty.
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b1;
        s_valid = '1; s_last = '0; s_data = '1;
        sa_s_ready = 1'b1; sa_m_valid = 1'b1; sa_m_last = 1'b1; sa_m_data = '0;
        m_ready = '1;
        #1;
        check({tag, "_rst_s_ready"}, s_ready, '0);
        check({tag, "_rst_sa_s_valid"}, sa_s_valid, 1'b0);
        check({tag, "_rst_sa_m_ready"}, sa_m_ready, 1'b0);
        check({tag, "_rst_m_valid"}, m_valid, '0);
        check({tag, "_rst_err"}, err, 1'b0);
        for (int i = 0; i < N; i++) begin
            rq[i].delete(); exp_q[i].delete(); exp_res[i].delete();
        end
        dest_q.delete(); res_q.delete(); cur_pkt.delete();
        in_pkt = 1'b0; mvld_hold = 1'b0; model_last = N - 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        s_valid = '0; s_data = '0; sa_s_ready = 1'b0;
        sa_m_valid = 1'b0; sa_m_last = 1'b0;
        rst = 1'b0;
        #1;
        check({tag, "_fifo_empty"}, sa_m_ready, 1'b0);
    endtask

    initial begin
        int i0;
        int d0;
        int n;
        rst = 1'b1;
        s_valid = '0; s_last = '0; s_data = '0;
        sa_s_ready = 1'b0; sa_m_valid = 1'b0; sa_m_last = 1'b0; sa_m_data = '0;
        m_ready = '0;
        cyc = 0; pop_cyc = 0; pkts_issued = 0; pkts_delivered = 0; fwd_beats = 0;
        force_mvld = 1'b0; watch_rdy = 1'b0; mrdy_target = 0;
        do_reset("init");

        // Single 6-beat packet from requester 0, everything always ready.
        sa_rdy_pct = 100; mvld_pct = 100; mrdy_mode = 1;
        i0 = fwd_beats; d0 = pkts_delivered;
        res_log.delete();
        load_pkt(0, 6);
        drain("t1", 200);
        check("t1_beats", fwd_beats - i0, 6);
        check("t1_pkts", pkts_delivered - d0, 1);
        check("t1_dest", res_log.size() > 0 ? res_log[0] : -1, 0);
        @(negedge clk); m_ready = '1; #1;
        check("t1_count_zero", sa_m_ready, 1'b0);

        // Both requesters always valid: strict alternation starting at requester 0.
        do_reset("t2");
        grant_log.delete(); res_log.delete();
        for (int k = 0; k < 4; k++) begin load_pkt(0, 6); load_pkt(1, 6); end
        drain("t2", 600);
        check("t2_grants", grant_log.size(), 8);
        check("t2_results", res_log.size(), 8);
        for (int k = 0; k < grant_log.size(); k++) check("t2_grant_order", grant_log[k], k % 2);
        for (int k = 0; k < res_log.size(); k++)  check("t2_result_order", res_log[k], k % 2);

        // Results never accepted: only D packets may be issued, then one pop frees one slot.
        mrdy_mode = 0;
        i0 = pkts_issued;
        for (int k = 0; k < 6; k++) load_pkt(0, 3);
        repeat (120) step();
        check("t3_issued_full", pkts_issued - i0, D);
        check("t3_idle_hold", last_s_ready, '0);
        mrdy_target = pkts_delivered + 1;
        watch_rdy = 1'b1;
        mrdy_mode = 3;
        repeat (40) step();
        check("t3_regrant_seen", watch_rdy, 1'b0);
        check("t3_issued_after_pop", pkts_issued - i0, D + 1);
        mrdy_mode = 2;
        drain("t3", 600);

        // Random backpressure on every side, random packet lengths including single-beat.
        sa_rdy_pct = 50; mvld_pct = 70; mrdy_mode = 2;
        d0 = pkts_delivered;
        for (int k = 0; k < 20; k++) load_pkt($urandom_range(N - 1), $urandom_range(6, 1));
        drain("t4", 4000);
        check("t4_delivered", pkts_delivered - d0, 20);

        // Reset on beat 3 of a 6-beat packet; requester 0 must win the next grant.
        sa_rdy_pct = 100; mvld_pct = 100; mrdy_mode = 1;
        load_pkt(1, 6);
        load_pkt(0, 6);
        n = 0;
        while (!(in_pkt && cur_pkt.size() == 3) && n < 100) begin step(); n++; end
        check("t5_mid_packet", cur_pkt.size(), 3);
        do_reset("t5");
        grant_log.delete();
        load_pkt(1, 3);
        load_pkt(0, 3);
        drain("t5", 300);
        check("t5_first_grant", grant_log.size() > 0 ? grant_log[0] : -1, 0);
        check("t5_no_err", err, 1'b0);

        // Array output with no outstanding tag sets the sticky error.
        force_mvld = 1'b1;
        step();
        #2;
        check("t6_err_set", err, 1'b1);
        force_mvld = 1'b0;
        repeat (3) step();
        #2;
        check("t6_err_sticky", err, 1'b1);
        do_reset("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
